// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding, line-code
// constants and the clock-to-bit divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [1:0] STOP_1   = 2'b00;
  localparam logic [1:0] STOP_1P5 = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;

  function automatic int unsigned bit_divisor(input int unsigned clk_frq,
                                              input int unsigned baud_rate);
    return clk_frq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a registered falling-edge detect.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rxs,
  output logic fall
);

  logic meta_q, meta_d;
  logic rxs_q, rxs_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = rx;
    rxs_d  = meta_q;
    prev_d = rxs_q;
  end

  // Idle-high reset values so a line that is already high never looks like an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      rxs_q  <= rxs_d;
      prev_q <= prev_d;
    end
  end

  assign rxs  = rxs_q;
  assign fall = prev_q & ~rxs_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver that collects bytes into a packet, delivered on idle timeout
// or when the packet buffer fills.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned Baud_rate  = 115200,
  parameter int unsigned clk_frq    = 100000000,
  parameter int unsigned data_depth = 36,
  parameter int unsigned idle_bits  = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  input  logic [3:0]                data_bits,
  input  logic [1:0]                stop_bits,
  input  logic [1:0]                parity,
  output logic [data_depth*8-1:0]   receive_data,
  output logic [5:0]                receive_data_bytes,
  output logic                      rx_done,
  output logic                      parity_error,
  output logic                      frame_error
);

  localparam int unsigned DIV       = bit_divisor(clk_frq, Baud_rate);
  localparam int unsigned BW        = data_depth * 8;
  localparam logic [15:0] D_LAST    = 16'(DIV - 1);
  localparam logic [15:0] H_LAST    = 16'(DIV / 2 - 1);
  localparam logic [15:0] IDLE_LAST = 16'(idle_bits - 1);
  localparam logic [5:0]  DEPTH     = 6'(data_depth);

  logic rxs, fall;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rxs  (rxs),
    .fall (fall)
  );

  rx_state_e     state_q, state_d;
  logic          from_gap_q, from_gap_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [5:0]    wcnt_q, wcnt_d;
  logic [15:0]   idle_q, idle_d;
  logic [BW-1:0] data_q, data_d;
  logic [5:0]    bytes_q, bytes_d;
  logic          done_q, done_d;
  logic          perr_out_q, perr_out_d;
  logic          ferr_out_q, ferr_out_d;

  logic [2:0]    last_bit;
  logic          parity_on;
  logic          deliver;
  logic [BW-1:0] buf_push;
  logic [5:0]    wcnt_inc;

  // Extra stop time is plain idle line to GAP, so the stop code only matters to a transmitter.
  logic stop_bits_unused;
  assign stop_bits_unused = ^stop_bits;

  always_comb begin
    case (data_bits)
      4'd5:    last_bit = 3'd4;
      4'd6:    last_bit = 3'd5;
      4'd7:    last_bit = 3'd6;
      default: last_bit = 3'd7;
    endcase
  end

  assign parity_on = (parity == PAR_EVEN) || (parity == PAR_ODD);
  assign buf_push  = (buf_q << 8) | BW'(shift_q);
  assign wcnt_inc  = wcnt_q + 6'd1;

  always_comb begin
    state_d    = state_q;
    from_gap_d = from_gap_q;
    cnt_d      = cnt_q + 16'd1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    buf_d      = buf_q;
    wcnt_d     = wcnt_q;
    idle_d     = idle_q;
    data_d     = data_q;
    bytes_d    = bytes_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    done_d     = 1'b0;
    deliver    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d    = S_START;
          from_gap_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == H_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = from_gap_q ? S_GAP : S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
            shift_d = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == D_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rxs;
          bit_d          = bit_q + 3'd1;
          if (bit_q == last_bit) state_d = parity_on ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (cnt_q == D_LAST) begin
          cnt_d   = '0;
          state_d = S_STOP;
          if (rxs != ((parity == PAR_ODD) ? ~^shift_q : ^shift_q)) perr_d = 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == D_LAST) begin
          cnt_d   = '0;
          idle_d  = '0;
          state_d = S_GAP;
          if (rxs) begin
            buf_d  = buf_push;
            wcnt_d = wcnt_inc;
            if (wcnt_inc == DEPTH) deliver = 1'b1;
          end else begin
            // A low line here can only restart after it rises, which the edge detect enforces.
            ferr_d = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (fall) begin
          state_d    = S_START;
          from_gap_d = 1'b1;
          cnt_d      = '0;
          idle_d     = '0;
        end else if (!rxs) begin
          cnt_d  = '0;
          idle_d = '0;
        end else if (cnt_q == D_LAST) begin
          cnt_d  = '0;
          idle_d = idle_q + 16'd1;
          if (idle_q == IDLE_LAST) begin
            if ((wcnt_q != '0) || ferr_q) deliver = 1'b1;
            else                          state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (deliver) begin
      data_d     = buf_d;
      bytes_d    = wcnt_d;
      perr_out_d = perr_d;
      ferr_out_d = ferr_d;
      done_d     = 1'b1;
      buf_d      = '0;
      wcnt_d     = '0;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;
      idle_d     = '0;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      from_gap_q <= 1'b0;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      buf_q      <= '0;
      wcnt_q     <= '0;
      idle_q     <= '0;
      data_q     <= '0;
      bytes_q    <= '0;
      done_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      from_gap_q <= from_gap_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      buf_q      <= buf_d;
      wcnt_q     <= wcnt_d;
      idle_q     <= idle_d;
      data_q     <= data_d;
      bytes_q    <= bytes_d;
      done_q     <= done_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
    end
  end

  assign receive_data       = data_q;
  assign receive_data_bytes = bytes_q;
  assign rx_done            = done_q;
  assign parity_error       = perr_out_q;
  assign frame_error        = ferr_out_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: table of framed packets plus hand-written
// sequences for full buffer, glitch, framing error and mid-byte reset.
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int unsigned CLK_FRQ = 3200000;
  localparam int unsigned BAUD    = 100000;
  localparam int unsigned DEPTH   = 36;
  localparam int unsigned IDLE    = 20;
  localparam int unsigned D       = CLK_FRQ / BAUD;
  localparam int unsigned H       = D / 2;

  logic                 clk, rst, rx;
  logic [3:0]           data_bits;
  logic [1:0]           stop_bits, parity;
  logic [DEPTH*8-1:0]   receive_data;
  logic [5:0]           receive_data_bytes;
  logic                 rx_done, parity_error, frame_error;

  uart_rx_frame #(
    .Baud_rate  (BAUD),
    .clk_frq    (CLK_FRQ),
    .data_depth (DEPTH),
    .idle_bits  (IDLE)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .rx                 (rx),
    .data_bits          (data_bits),
    .stop_bits          (stop_bits),
    .parity             (parity),
    .receive_data       (receive_data),
    .receive_data_bytes (receive_data_bytes),
    .rx_done            (rx_done),
    .parity_error       (parity_error),
    .frame_error        (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned done_cyc = 0;
  int unsigned last_start_cyc = 0;
  int unsigned passed = 0;
  int unsigned total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int unsigned eff_bits(input logic [3:0] code);
    case (code)
      4'd5:    return 5;
      4'd6:    return 6;
      4'd7:    return 7;
      default: return 8;
    endcase
  endfunction

  task automatic drive_bit(input logic b, input int unsigned n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  // One character using the current configuration inputs; flip inverts the parity bit.
  task automatic send_byte(input logic [7:0] b, input logic flip, input logic stop_lvl);
    int unsigned nb;
    logic [7:0]  m;
    logic        p;
    nb = eff_bits(data_bits);
    m  = b & ((8'd1 << nb) - 8'd1);
    last_start_cyc = cyc;
    drive_bit(1'b0, D);
    for (int unsigned i = 0; i < nb; i++) drive_bit(m[i], D);
    if (parity == PAR_EVEN || parity == PAR_ODD) begin
      p = ^m;
      if (parity == PAR_ODD) p = ~p;
      drive_bit(p ^ flip, D);
    end
    case (stop_bits)
      STOP_1P5: drive_bit(stop_lvl, D + H);
      STOP_2:   drive_bit(stop_lvl, 2 * D);
      default:  drive_bit(stop_lvl, D);
    endcase
  endtask

  task automatic idle_out();
    drive_bit(1'b1, (IDLE + 3) * D);
  endtask

  typedef struct {
    logic [3:0]       dbits;
    logic [1:0]       par;
    logic [1:0]       stp;
    int unsigned      n;
    logic [2:0][7:0]  b;      // b[0] is sent first
    logic [2:0]       flip;
    logic [5:0]       exp_n;
    logic [31:0]      exp_data;
    logic             exp_perr;
    logic             exp_ferr;
  } vec_t;

  vec_t vecs[5];
  int unsigned d0, lat;

  initial begin
    vecs[0] = '{4'd8, PAR_NONE, STOP_1,   2, {8'h00, 8'hA3, 8'h55}, 3'b000, 6'd2, 32'h0000_55A3, 1'b0, 1'b0};
    vecs[1] = '{4'd7, PAR_EVEN, STOP_2,   2, {8'h00, 8'h41, 8'h41}, 3'b010, 6'd2, 32'h0000_4141, 1'b1, 1'b0};
    vecs[2] = '{4'd5, PAR_ODD,  STOP_1,   2, {8'h00, 8'h0A, 8'h15}, 3'b000, 6'd2, 32'h0000_150A, 1'b0, 1'b0};
    vecs[3] = '{4'd3, 2'b11,    STOP_1P5, 3, {8'hFF, 8'h81, 8'hC3}, 3'b000, 6'd3, 32'h00C3_81FF, 1'b0, 1'b0};
    vecs[4] = '{4'd6, PAR_EVEN, STOP_1,   1, {8'h00, 8'h00, 8'h2D}, 3'b001, 6'd1, 32'h0000_002D, 1'b1, 1'b0};

    rst = 1'b0; rx = 1'b1;
    data_bits = 4'd8; stop_bits = STOP_1; parity = PAR_NONE;
    repeat (5) @(negedge clk);
    check("rst_data",  64'(receive_data == '0), 64'd1);
    check("rst_bytes", 64'(receive_data_bytes), 64'd0);
    check("rst_done",  64'(rx_done), 64'd0);
    check("rst_perr",  64'(parity_error), 64'd0);
    check("rst_ferr",  64'(frame_error), 64'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      data_bits = vecs[v].dbits; parity = vecs[v].par; stop_bits = vecs[v].stp;
      repeat (2) @(negedge clk);
      d0 = done_cnt;
      for (int unsigned k = 0; k < vecs[v].n; k++) send_byte(vecs[v].b[k], vecs[v].flip[k], 1'b1);
      idle_out();
      check($sformatf("v%0d_done", v),  64'(done_cnt - d0), 64'd1);
      check($sformatf("v%0d_bytes", v), 64'(receive_data_bytes), 64'(vecs[v].exp_n));
      check($sformatf("v%0d_data", v),  64'(receive_data[31:0]), 64'(vecs[v].exp_data));
      check($sformatf("v%0d_perr", v),  64'(parity_error), 64'(vecs[v].exp_perr));
      check($sformatf("v%0d_ferr", v),  64'(frame_error), 64'(vecs[v].exp_ferr));
    end

    // Full buffer: 36 back-to-back bytes deliver without waiting for idle.
    data_bits = 4'd8; parity = PAR_NONE; stop_bits = STOP_1;
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    for (int unsigned i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0, 1'b1);
    drive_bit(1'b1, 2 * D);
    lat = done_cyc - last_start_cyc;
    check("full_done",    64'(done_cnt - d0), 64'd1);
    // edge seen through 2 sync flops + edge register, then H to mid-start and 9 D to mid-stop
    check("full_latency", 64'(lat), 64'(9 * D + H + 3));
    check("full_bytes",   64'(receive_data_bytes), 64'd36);
    check("full_last",    64'(receive_data[7:0]), 64'h23);
    check("full_prev",    64'(receive_data[15:8]), 64'h22);
    check("full_first",   64'(receive_data[287:280]), 64'h00);
    drive_bit(1'b1, 25 * D);
    check("full_no_extra", 64'(done_cnt - d0), 64'd1);

    // Start glitch shorter than half a bit.
    d0 = done_cnt;
    drive_bit(1'b0, 7);
    drive_bit(1'b1, H + 8);
    check("glitch_state", 64'(dut.state_q), 64'(S_IDLE));
    drive_bit(1'b1, 25 * D);
    check("glitch_no_done", 64'(done_cnt - d0), 64'd0);
    send_byte(8'h5A, 1'b0, 1'b1);
    idle_out();
    check("glitch_after_done",  64'(done_cnt - d0), 64'd1);
    check("glitch_after_bytes", 64'(receive_data_bytes), 64'd1);
    check("glitch_after_data",  64'(receive_data[15:0]), 64'h005A);

    // Packet holding only a framing-errored byte.
    d0 = done_cnt;
    send_byte(8'h12, 1'b0, 1'b0);
    drive_bit(1'b0, 3 * D);
    idle_out();
    check("ferr_only_done",  64'(done_cnt - d0), 64'd1);
    check("ferr_only_bytes", 64'(receive_data_bytes), 64'd0);
    check("ferr_only_ferr",  64'(frame_error), 64'd1);
    check("ferr_only_perr",  64'(parity_error), 64'd0);

    // Framing error followed by a good byte in the same packet.
    d0 = done_cnt;
    send_byte(8'h12, 1'b0, 1'b0);
    drive_bit(1'b0, 3 * D);
    drive_bit(1'b1, D);
    send_byte(8'h34, 1'b0, 1'b1);
    idle_out();
    check("ferr_done",  64'(done_cnt - d0), 64'd1);
    check("ferr_bytes", 64'(receive_data_bytes), 64'd1);
    check("ferr_data",  64'(receive_data[15:0]), 64'h0034);
    check("ferr_flag",  64'(frame_error), 64'd1);
    check("ferr_perr",  64'(parity_error), 64'd0);

    // Reset during the 4th data bit of the second byte (0x5C, bit3 = 1).
    d0 = done_cnt;
    send_byte(8'h11, 1'b0, 1'b1);
    drive_bit(1'b0, D);
    drive_bit(1'b0, D);
    drive_bit(1'b0, D);
    drive_bit(1'b1, D);
    rx = 1'b1;
    repeat (H) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mrst_data",  64'(receive_data == '0), 64'd1);
    check("mrst_bytes", 64'(receive_data_bytes), 64'd0);
    check("mrst_done",  64'(rx_done), 64'd0);
    check("mrst_perr",  64'(parity_error), 64'd0);
    check("mrst_ferr",  64'(frame_error), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive_bit(1'b1, 25 * D);
    check("mrst_no_done", 64'(done_cnt - d0), 64'd0);
    send_byte(8'h7E, 1'b0, 1'b1);
    idle_out();
    check("mrst_after_done",  64'(done_cnt - d0), 64'd1);
    check("mrst_after_bytes", 64'(receive_data_bytes), 64'd1);
    check("mrst_after_data",  64'(receive_data[15:0]), 64'h007E);
    check("mrst_after_ferr",  64'(frame_error), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 Parameter Baud_rate, default 115200, line bit rate.
REQ-002 Parameter clk_frq, default 100000000, clk frequency in Hz.
REQ-003 Parameter data_depth, default 36, max bytes per packet (<=63).
REQ-004 Parameter idle_bits, default 20, idle line bit-periods that end a packet.
REQ-005 clk  in  1  clock; rst  in  1  reset, synchronous, active-low.
REQ-006 rx  in  1  asynchronous serial line, idle high.
REQ-007 data_bits  in  4  5/6/7/8 data bits; any other value is treated as 8.
REQ-008 stop_bits  in  2  00=1, 01=1.5, 10=2 stop bits.
REQ-009 parity  in  2  00=none, 01=even, 10=odd; 11 is treated as none.
REQ-010 receive_data  out  data_depth*8  packet bytes; the last-received byte is in [7:0] and earlier bytes sit above it.
REQ-011 receive_data_bytes  out  6  byte count of the packet in receive_data.
REQ-012 rx_done  out  1  one-cycle pulse when receive_data and receive_data_bytes update.
REQ-013 parity_error  out  1  set if any byte of the delivered packet failed parity.
REQ-014 frame_error  out  1  set if any stop bit of the delivered packet sampled 0.

Function
REQ-015 Bit period is D = clk_frq/Baud_rate clocks and half period is H = D/2 (integer division); the bit counter is 16 bits wide.
REQ-016 rx shall pass through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-017 States: IDLE, START, DATA, PARITY, STOP, GAP.
REQ-018 IDLE: on a rxs high-to-low edge, clear the counter and go to START.
REQ-019 START: at count H-1, sample rxs; if 1 (glitch), return to IDLE or GAP (whichever was the prior state); if 0, go to DATA with the counter reset.
REQ-020 DATA: sample every D clocks, i.e. at the mid-bit. Bits are LSB-first into an 8-bit shift register, right-justified, with unused upper bits zero. After data_bits samples, go to PARITY if parity is 01/10, else STOP.
REQ-021 PARITY: sample one bit. Even mode: error if the bit is not equal to XOR(data). Odd mode: error if the bit is not equal to ~XOR(data). An error sets the working parity flag.
REQ-022 STOP: sample the first stop bit only; the extra half or full stop bit is absorbed by GAP.
- Stop = 1: shift the byte into the working buffer (buffer << 8 | byte) and increment the working count.
- Stop = 0: discard the byte, set the working frame flag, and require rxs = 1 before any new start is accepted.
REQ-023 GAP: a rxs falling edge goes to START. Each D clocks of rxs high increments the idle counter; rxs low or a new start clears it.
REQ-024 Packet end occurs at idle_bits idle periods with working count >= 1, or immediately after the stop sample that makes working count == data_depth.
- At packet end: copy buffer, count, and flags to the outputs, pulse rx_done for 1 cycle, clear the working buffer, count, and flags, and go to IDLE.
REQ-025 A packet containing only frame-errored bytes (working count 0) at timeout shall still pulse rx_done with receive_data_bytes = 0 and frame_error = 1.
REQ-026 Outputs hold their values between rx_done pulses. Configuration inputs are sampled per bit and must remain stable during a packet.
REQ-027 Latency: rx_done occurs 1 cycle after the terminating stop sample (full case) or after the idle_bits-th idle period.

Reset
REQ-028 When rst = 0 at a clk edge: FSM goes to IDLE; all counters, the buffer, and flags go to 0; receive_data = 0, receive_data_bytes = 0, rx_done = 0, parity_error = 0, frame_error = 0; the synchronizer flops go to 1.
REQ-029 Reset mid-byte discards the partial packet with no rx_done. After reset, only a fresh high-to-low edge starts reception.

Structure
REQ-030 The shared package uart_pkg holds the state encoding, parity and stop-bit code constants, and a divisor function (clk_frq, Baud_rate).
REQ-031 A single sub-module uart_rx_sync provides the 2-flop synchronizer and falling-edge detect; everything else lives in uart_rx_frame.

Verification
REQ-032 Parameters D = 868, H = 434, 8N1: send 0x55, 0xA3, then idle 20 bits -> rx_done once, receive_data_bytes = 2, receive_data[15:0] = 0x55A3, both error flags 0.
REQ-033 7E2: send 0x41 with a correct even parity bit, then 0x41 with the parity bit flipped -> 2 bytes delivered, parity_error = 1, frame_error = 0.
REQ-034 8N1, data_depth = 36: send 36 back-to-back bytes 0x00..0x23 -> rx_done 1 cycle after the 36th stop sample, count = 36, receive_data[7:0] = 0x23, receive_data[287:280] = 0x00.
REQ-035 Glitch: rx low for 200 clks then high -> no byte captured, FSM back to IDLE, and no rx_done after 20 idle bits.
REQ-036 Frame error: send 0x12 with stop = 0, hold low 3 bits, release, then send 0x34 -> count = 1, data[7:0] = 0x34, frame_error = 1.
REQ-037 Assert rst = 0 during the 4th data bit of byte 2 -> all outputs 0, no rx_done; a subsequent 0x7E is received correctly as a 1-byte packet.
